sha256_target_checker: RTL
==========================

// Module: sha256_target_checker
// PURPOSE
//  Downstream of sha256_3_pipeline. Consumes one 256-bit digest per cycle, tags each digest with its nonce,
//  and compares the digest against the share target in Bitcoin numeric order.
//  Pushes the nonces of qualifying digests into a small result FIFO that the host/UART side drains.
// PARAMETERS
//  NONCE_W     32  width of nonce tag and nonce counter
//  FIFO_DEPTH  4   result FIFO entries (power of 2, >=2)
// PORTS
//  CLK          in   1        system clock
//  RST          in   1        asynchronous, active-high reset
//  start        in   1        pulse: load nonce_base and target, flush compare pipeline
//  nonce_base   in   NONCE_W  nonce of first digest after start
//  target       in   256      share target, numeric big-endian
//  digest_in    in   256      pipeline digest_out, raw byte order
//  digest_valid in   1        pipeline valid_out
//  res_valid    out  1        FIFO non-empty
//  res_nonce    out  NONCE_W  FIFO head
//  res_ready    in   1        pop when res_valid&&res_ready
//  hit_count    out  32       total hits detected since reset (saturating)
//  overflow     out  1        sticky: a hit was dropped on full FIFO
// BEHAVIOUR
//  Reset: nonce_cnt=0, target_reg=0, pipe valids=0, FIFO empty, res_valid=0, res_nonce=0, hit_count=0, overflow=0.
//  Start: nonce_cnt<=nonce_base; target_reg<=target; S1/S2 valid bits cleared; FIFO contents/overflow kept.
//  Start + digest_valid in same cycle: the digest is tagged nonce_base and nonce_cnt<=nonce_base+1.
//  Tagging: each digest_valid cycle tags digest with nonce_cnt and increments it; modulo 2^NONCE_W (FFFFFFFF->0).
//  Ordering: digest bytes reversed before compare (byte 0 of digest_in = MSB of value).
//  S1 (cycle+1): register per-64-bit-chunk lt/eq flags vs target_reg, plus tag and valid.
//  S2 (cycle+2): hit = value < target_reg (strict), combined MSB chunk first; register hit, tag.
//  FIFO push at S2 output: visible on res_valid the cycle after the S2 register (3 cycles from digest_valid).
//  Equal value is not a hit. target_reg=0 => never a hit.
//  Throughput: one digest per cycle, no backpressure toward the pipeline; digest_valid gaps allowed.
//  FIFO full + hit + pop in the same cycle: push accepted and count unchanged, no overflow.
//  FIFO full + hit, no pop: hit dropped, overflow<=1 (cleared only by RST); hit_count still increments.
//  Empty FIFO: a pop attempt is ignored; res_nonce holds its last value.
//  hit_count saturates at FFFFFFFF.
//  res_nonce comes from a registered FIFO head: stable while res_valid && !res_ready.
//  RST mid-operation: all state is lost immediately; in-flight digests are discarded.
// STRUCTURE
//  Shared package sha256_miner_pkg holds:
//    DIGEST_W=256, NONCE_W default, and function byte_rev256().
//  Sub-module nonce_fifo: synchronous FIFO with async-high RST. It has:
//    push/pop/full/empty, registered head, and an explicit occupancy count.
//  Top level: nonce counter, target register, 2-stage compare, hit counter, overflow flag.
// TESTING
//  1 start nonce_base=0, target=00000000FFFF0000..0; feed digest 5c8ad782c007cc563f8db735180b35dab8c983d172b57e2c2701000000000000
//    -> res_valid=1 three cycles later, res_nonce=0.
//  2 same setup; stream 1FB5FEB0..DF2E, F56A912E..209F, 305338AC..C674 back-to-back
//    -> no push, hit_count unchanged.
//  3 target=all-ones, nonce_base=FFFFFFFE, 4 digests consecutive
//    -> FIFO holds FFFFFFFE, FFFFFFFF, 0, 1 in order (wrap).
//  4 res_ready=0; 5 hits with target=all-ones
//    -> 4 entries kept, overflow=1, hit_count=5.
//    Repeat with res_ready=1 on the 5th-hit push cycle -> no overflow.
//  5 start asserted while 2 digests are in flight
//    -> neither is pushed; the next digest is tagged nonce_base.
//  6 assert RST mid-stream -> all outputs at reset values on the next sample.

Source files
------------

// File: rtl/sha256_miner_pkg.sv
// Shared widths and helpers for the miner datapath.
package sha256_miner_pkg;
  localparam int DIGEST_W = 256;
  localparam int NONCE_W  = 32;
  localparam int CHUNKS   = 4;

  // Digest bytes arrive least-significant byte first; byte 0 becomes the value's MSB.
  function automatic logic [DIGEST_W-1:0] byte_rev256(input logic [DIGEST_W-1:0] d);
    logic [DIGEST_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGEST_W / 8; i++) begin
      r[DIGEST_W-1-8*i -: 8] = d[8*i +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/nonce_fifo.sv
// Result FIFO with registered head; a push is visible one cycle later.
// A push to a full FIFO is accepted only when a pop happens in the same cycle; pops on empty are ignored.
module nonce_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count, remain, count_next;
  logic          push_ok, pop_ok;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign pop_ok     = pop && !empty;
  assign push_ok    = push && (!full || pop_ok);
  assign rd_next    = rd_ptr + AW'(pop_ok);
  assign remain     = count - (AW+1)'(pop_ok);
  assign count_next = remain + (AW+1)'(push_ok);

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_next;
      count  <= count_next;
      // The entry being written becomes head when nothing older remains; empty keeps the last head.
      if (count_next != '0) head <= (remain == '0) ? din : mem[rd_next];
    end
  end
endmodule

// File: rtl/sha256_target_checker.sv
// Tags digests with nonces, compares against the share target in 2 stages, queues hit nonces.
// Hit visible on res_valid 3 cycles after digest_valid; no backpressure toward the hash pipeline.
module sha256_target_checker #(
  parameter int NONCE_W    = sha256_miner_pkg::NONCE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [255:0]       target,
  input  logic [255:0]       digest_in,
  input  logic               digest_valid,
  output logic               res_valid,
  output logic [NONCE_W-1:0] res_nonce,
  input  logic               res_ready,
  output logic [31:0]        hit_count,
  output logic               overflow
);
  import sha256_miner_pkg::*;

  localparam int CW = DIGEST_W / CHUNKS;

  logic [NONCE_W-1:0]  nonce_cnt, tag, s1_tag, s2_tag;
  logic [DIGEST_W-1:0] target_reg, cmp_target, value;
  logic [CHUNKS-1:0]   lt_c, eq_c, s1_lt, s1_eq;
  logic                s1_vld, s2_vld, s2_hit, s1_hit_c;
  logic                hit, drop, fifo_full, fifo_empty;

  assign value      = byte_rev256(digest_in);
  // A digest arriving with start belongs to the new job.
  assign cmp_target = start ? target : target_reg;
  assign tag        = start ? nonce_base : nonce_cnt;

  always_comb begin
    lt_c = '0;
    eq_c = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      lt_c[i] = value[i*CW +: CW] <  cmp_target[i*CW +: CW];
      eq_c[i] = value[i*CW +: CW] == cmp_target[i*CW +: CW];
    end
  end

  // Fold from the least significant chunk up so higher chunks dominate.
  always_comb begin
    s1_hit_c = 1'b0;
    for (int i = 0; i < CHUNKS; i++) begin
      s1_hit_c = s1_lt[i] | (s1_eq[i] & s1_hit_c);
    end
  end

  assign hit  = s2_vld && s2_hit && !start;
  assign drop = hit && fifo_full && !res_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nonce_cnt  <= '0;
      target_reg <= '0;
      s1_vld     <= 1'b0;
      s1_lt      <= '0;
      s1_eq      <= '0;
      s1_tag     <= '0;
      s2_vld     <= 1'b0;
      s2_hit     <= 1'b0;
      s2_tag     <= '0;
      hit_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (start) begin
        nonce_cnt  <= nonce_base + NONCE_W'(digest_valid);
        target_reg <= target;
      end else if (digest_valid) begin
        nonce_cnt <= nonce_cnt + NONCE_W'(1);
      end
      s1_vld <= digest_valid;
      s1_lt  <= lt_c;
      s1_eq  <= eq_c;
      s1_tag <= tag;
      s2_vld <= s1_vld && !start;
      s2_hit <= s1_hit_c;
      s2_tag <= s1_tag;
      if (hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  nonce_fifo #(
    .W     (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (hit),
    .din   (s2_tag),
    .pop   (res_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (res_nonce)
  );

  assign res_valid = !fifo_empty;
endmodule
